// File: rtl/reg_writeback_if.sv
// Execute/LSU-to-register-file write-side bundle for reg_writeback.
// RF_BYPASS_EN adds the forwarding data returned to decode.
interface reg_writeback_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        ld_issue_valid;
  logic [4:0]  ld_issue_rd;
  logic        ld_issue_ready;
  logic        ld_resp_valid;
  logic [31:0] ld_resp_data;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        we;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        ld_err;
`ifdef RF_BYPASS_EN
  logic [31:0] rs1_fwd_data;
  logic [31:0] rs2_fwd_data;
`endif

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    output alu_ready,
    input  ld_issue_valid, ld_issue_rd,
    output ld_issue_ready,
    input  ld_resp_valid, ld_resp_data,
    input  rs1_addr, rs2_addr,
    output rs1_busy, rs2_busy,
`ifdef RF_BYPASS_EN
    output rs1_fwd_data, rs2_fwd_data,
`endif
    output we, rd_addr, rd_data, ld_err
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    input  alu_ready,
    output ld_issue_valid, ld_issue_rd,
    input  ld_issue_ready,
    output ld_resp_valid, ld_resp_data,
    output rs1_addr, rs2_addr,
    input  rs1_busy, rs2_busy,
`ifdef RF_BYPASS_EN
    input  rs1_fwd_data, rs2_fwd_data,
`endif
    input  we, rd_addr, rd_data, ld_err
  );
endinterface

// File: rtl/reg_writeback.sv
// Register-file write port arbiter: ALU results + in-order load responses, load-destination
// scoreboard and RAW hazard reporting. Optional macro RF_BYPASS_EN forwards the output stage.
module reg_writeback #(
  parameter int unsigned LD_DEPTH = 4
) (
  input logic            clk,
  input logic            reset,
  reg_writeback_if.slave bus
);
  localparam int unsigned PW = $clog2(LD_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [4:0]          pend_rd [LD_DEPTH];
  logic [LD_DEPTH-1:0] pend_vld;
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       count;

  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  logic       alu_take;
  logic       alu_hit;
  logic       rs1_pend;
  logic       rs2_pend;
  logic       rs1_out;
  logic       rs2_out;
  logic [4:0] head_rd;

  // Scoreboard lookups against every live pending destination
  always_comb begin
    alu_hit  = 1'b0;
    rs1_pend = 1'b0;
    rs2_pend = 1'b0;
    for (int i = 0; i < int'(LD_DEPTH); i++) begin
      if (pend_vld[i] && pend_rd[i] == bus.alu_rd)   alu_hit  = 1'b1;
      if (pend_vld[i] && pend_rd[i] == bus.rs1_addr) rs1_pend = 1'b1;
      if (pend_vld[i] && pend_rd[i] == bus.rs2_addr) rs2_pend = 1'b1;
    end
  end

  assign full     = (count == CW'(LD_DEPTH));
  assign empty    = (count == '0);
  assign push     = bus.ld_issue_valid && !full;
  assign pop      = bus.ld_resp_valid && !empty;
  assign head_rd  = pend_rd[rd_ptr];

  assign bus.ld_issue_ready = !full;
  // Loads own the port; ALU also waits behind an older pending load to the same rd
  assign bus.alu_ready = !bus.ld_resp_valid && !((bus.alu_rd != 5'd0) && alu_hit);
  assign alu_take      = bus.alu_valid && bus.alu_ready;

  assign rs1_out = bus.we && (bus.rd_addr == bus.rs1_addr);
  assign rs2_out = bus.we && (bus.rd_addr == bus.rs2_addr);

`ifdef RF_BYPASS_EN
  assign bus.rs1_busy     = (bus.rs1_addr != 5'd0) && rs1_pend;
  assign bus.rs2_busy     = (bus.rs2_addr != 5'd0) && rs2_pend;
  assign bus.rs1_fwd_data = (rs1_out && bus.rs1_addr != 5'd0) ? bus.rd_data : 32'd0;
  assign bus.rs2_fwd_data = (rs2_out && bus.rs2_addr != 5'd0) ? bus.rd_data : 32'd0;
`else
  assign bus.rs1_busy = (bus.rs1_addr != 5'd0) && (rs1_pend || rs1_out);
  assign bus.rs2_busy = (bus.rs2_addr != 5'd0) && (rs2_pend || rs2_out);
`endif

  // Pending-destination FIFO; push and pop never share a slot (empty or full excludes one)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pend_vld <= '0;
    end else begin
      if (push) begin
        pend_rd[wr_ptr]  <= bus.ld_issue_rd;
        pend_vld[wr_ptr] <= 1'b1;
        wr_ptr           <= PW'(wr_ptr + 1'b1);
      end
      if (pop) begin
        pend_vld[rd_ptr] <= 1'b0;
        rd_ptr           <= PW'(rd_ptr + 1'b1);
      end
      case ({push, pop})
        2'b10:   count <= CW'(count + 1'b1);
        2'b01:   count <= CW'(count - 1'b1);
        default: count <= count;
      endcase
    end
  end

  // Registered write port; x0 destinations consume the slot without enabling the write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.we      <= 1'b0;
      bus.rd_addr <= 5'd0;
      bus.rd_data <= 32'd0;
      bus.ld_err  <= 1'b0;
    end else begin
      bus.we <= 1'b0;
      if (pop) begin
        bus.we      <= (head_rd != 5'd0);
        bus.rd_addr <= head_rd;
        bus.rd_data <= bus.ld_resp_data;
      end else if (alu_take) begin
        bus.we      <= (bus.alu_rd != 5'd0);
        bus.rd_addr <= bus.alu_rd;
        bus.rd_data <= bus.alu_data;
      end
      if (bus.ld_resp_valid && empty) bus.ld_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: directed scenarios then random traffic
// against a queue-based model of pending loads and the write port.
module tb_reg_writeback;
  localparam int unsigned LD_DEPTH = 4;

  logic clk;
  logic reset;
  reg_writeback_if bus ();

  reg_writeback #(.LD_DEPTH(LD_DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Model state: in-order pending destinations and the expected write port
  logic [4:0]  q[$];
  logic        exp_we;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;
  logic        exp_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic bit in_q(input logic [4:0] r);
    foreach (q[i]) if (q[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit exp_busy(input logic [4:0] r);
`ifdef RF_BYPASS_EN
    return (r != 5'd0) && in_q(r);
`else
    return (r != 5'd0) && (in_q(r) || (exp_we && exp_addr == r));
`endif
  endfunction

  task automatic idle();
    bus.alu_valid = 1'b0; bus.alu_rd = 5'd0; bus.alu_data = 32'd0;
    bus.ld_issue_valid = 1'b0; bus.ld_issue_rd = 5'd0;
    bus.ld_resp_valid = 1'b0; bus.ld_resp_data = 32'd0;
    bus.rs1_addr = 5'd0; bus.rs2_addr = 5'd0;
  endtask

  // One clock: check combinational outputs, advance, update model, check registered outputs
  task automatic step();
    bit m_iready, m_ready;
    logic [4:0] h;
    #1;
    m_iready = (q.size() < LD_DEPTH);
    m_ready  = !bus.ld_resp_valid && !(bus.alu_rd != 5'd0 && in_q(bus.alu_rd));
    chk("alu_ready", 32'(bus.alu_ready), 32'(m_ready));
    chk("ld_issue_ready", 32'(bus.ld_issue_ready), 32'(m_iready));
    chk("rs1_busy", 32'(bus.rs1_busy), 32'(exp_busy(bus.rs1_addr)));
    chk("rs2_busy", 32'(bus.rs2_busy), 32'(exp_busy(bus.rs2_addr)));
`ifdef RF_BYPASS_EN
    if (bus.rs1_addr != 5'd0 && exp_we && exp_addr == bus.rs1_addr)
      chk("rs1_fwd", bus.rs1_fwd_data, exp_data);
    if (bus.rs2_addr != 5'd0 && exp_we && exp_addr == bus.rs2_addr)
      chk("rs2_fwd", bus.rs2_fwd_data, exp_data);
`endif
    @(posedge clk);
    #1;
    exp_we = 1'b0;
    if (bus.ld_resp_valid) begin
      if (q.size() > 0) begin
        h = q.pop_front();
        exp_we = (h != 5'd0); exp_addr = h; exp_data = bus.ld_resp_data;
      end else begin
        exp_err = 1'b1;
      end
    end else if (bus.alu_valid && m_ready) begin
      exp_we = (bus.alu_rd != 5'd0); exp_addr = bus.alu_rd; exp_data = bus.alu_data;
    end
    if (bus.ld_issue_valid && m_iready) q.push_back(bus.ld_issue_rd);
    chk("we", 32'(bus.we), 32'(exp_we));
    chk("ld_err", 32'(bus.ld_err), 32'(exp_err));
    if (exp_we) begin
      chk("rd_addr", 32'(bus.rd_addr), 32'(exp_addr));
      chk("rd_data", bus.rd_data, exp_data);
    end
  endtask

  // Asynchronous reset applied off-edge; outputs checked while reset is held
  task automatic do_reset();
    reset = 1'b1;
    #2;
    q.delete();
    exp_we = 1'b0; exp_addr = 5'd0; exp_data = 32'd0; exp_err = 1'b0;
    chk("rst_we", 32'(bus.we), 32'd0);
    chk("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
    chk("rst_rd_data", bus.rd_data, 32'd0);
    chk("rst_ld_err", 32'(bus.ld_err), 32'd0);
    chk("rst_issue_ready", 32'(bus.ld_issue_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    #3;
    do_reset();

    // 1: ALU write, then RAW visibility on the output stage
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h1234;
    step();
    chk("t1_we", 32'(bus.we), 32'd1);
    chk("t1_addr", 32'(bus.rd_addr), 32'd5);
    chk("t1_data", bus.rd_data, 32'h1234);
    idle(); bus.rs1_addr = 5'd5;
    #1;
`ifndef RF_BYPASS_EN
    chk("t1_rs1_busy", 32'(bus.rs1_busy), 32'd1);
`endif
    step();

    // 2: load response preempts ALU, ALU retried next cycle
    idle(); bus.ld_issue_valid = 1'b1; bus.ld_issue_rd = 5'd7;
    step();
    idle(); bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h3333;
    bus.ld_resp_valid = 1'b1; bus.ld_resp_data = 32'hCAFE;
    #1;
    chk("t2_alu_ready", 32'(bus.alu_ready), 32'd0);
    step();
    chk("t2_addr", 32'(bus.rd_addr), 32'd7);
    chk("t2_data", bus.rd_data, 32'hCAFE);
    bus.ld_resp_valid = 1'b0;
    step();
    chk("t2_retry_addr", 32'(bus.rd_addr), 32'd3);

    // 3: fill the FIFO, refused issue on simultaneous pop, in-order drain
    for (int i = 1; i <= 4; i++) begin
      idle(); bus.ld_issue_valid = 1'b1; bus.ld_issue_rd = 5'(i);
      step();
    end
    idle();
    #1;
    chk("t3_full", 32'(bus.ld_issue_ready), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      idle(); bus.ld_resp_valid = 1'b1; bus.ld_resp_data = 32'h100 + 32'(i);
      if (i == 1) begin bus.ld_issue_valid = 1'b1; bus.ld_issue_rd = 5'd9; end
      step();
      chk("t3_order", 32'(bus.rd_addr), 32'(i));
    end
    idle();
    #1;
    chk("t3_empty_ready", 32'(bus.ld_issue_ready), 32'd1);

    // 4: x0 destination accepted without a write
    idle(); bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'hFFFF;
    #1;
    chk("t4_alu_ready", 32'(bus.alu_ready), 32'd1);
    step();
    chk("t4_we", 32'(bus.we), 32'd0);
    idle(); bus.rs1_addr = 5'd0;
    step();

    // 5: response with empty FIFO, then reset with two loads pending
    idle(); bus.ld_resp_valid = 1'b1; bus.ld_resp_data = 32'hDEAD;
    step();
    chk("t5_err", 32'(bus.ld_err), 32'd1);
    for (int i = 0; i < 2; i++) begin
      idle(); bus.ld_issue_valid = 1'b1; bus.ld_issue_rd = 5'd12 + 5'(i);
      step();
    end
    idle();
    do_reset();
    bus.rs1_addr = 5'd12; bus.rs2_addr = 5'd13;
    #1;
    chk("t5_rs1_clear", 32'(bus.rs1_busy), 32'd0);
    chk("t5_rs2_clear", 32'(bus.rs2_busy), 32'd0);
    step();

`ifdef RF_BYPASS_EN
    // 6: forwarding of the output stage instead of stalling
    idle(); bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'hABCD;
    step();
    idle(); bus.rs2_addr = 5'd9;
    #1;
    chk("t6_busy", 32'(bus.rs2_busy), 32'd0);
    chk("t6_fwd", bus.rs2_fwd_data, 32'hABCD);
    step();
`endif

    // Random traffic over a small register range to provoke hazards
    for (int c = 0; c < 400; c++) begin
      bus.alu_valid      = 1'($urandom_range(0, 1));
      bus.alu_rd         = 5'($urandom_range(0, 7));
      bus.alu_data       = $urandom;
      bus.ld_issue_valid = ($urandom_range(0, 99) < 45);
      bus.ld_issue_rd    = 5'($urandom_range(0, 7));
      bus.ld_resp_valid  = (q.size() > 0) ? ($urandom_range(0, 99) < 35)
                                          : ($urandom_range(0, 99) < 3);
      bus.ld_resp_data   = $urandom;
      bus.rs1_addr       = 5'($urandom_range(0, 7));
      bus.rs2_addr       = 5'($urandom_range(0, 7));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
